// File: rtl/rr_sel_pkg.sv
// rr_sel_pkg: shared state encoding and bus constants for the round-robin select arbiter
package rr_sel_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
    localparam logic [7:0] SEL_NONE = 8'hFF;
    localparam logic [1:0] ENA_ON   = 2'b01;
endpackage

// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if: request/release handshake and active-low select bus of the arbiter
interface rr_sel_arbiter_if;
    logic [1:0] ena;
    logic [7:0] req;
    logic       done;
    logic [7:0] sel_n;
    logic [2:0] gnt_idx;
    logic       valid;
    logic       timeout;
    modport master(output ena, req, done, input sel_n, gnt_idx, valid, timeout);
    modport slave(input ena, req, done, output sel_n, gnt_idx, valid, timeout);
endinterface

// File: rtl/sel_dec3to8.sv
// sel_dec3to8: 3-to-8 active-low decoder with enable; all lines high when disabled
module sel_dec3to8
    import rr_sel_pkg::*;
(
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] sel_n
);
    assign sel_n = en ? ~(8'b1 << idx) : SEL_NONE;
endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: 8-way round-robin arbiter with hold timeout and a one-cycle dead gap between owners
module rr_sel_arbiter
    import rr_sel_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic clk,
    input logic rst_n,
    rr_sel_arbiter_if.slave bus
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    state_t     state;
    logic [2:0] ptr;
    logic [7:0] cnt;
    logic [7:0] rot;
    logic [2:0] first;
    logic [2:0] win;
    logic       ena_on;
    logic       rel_early;
    logic       rel_hold;
    logic       grant;
    logic       release_own;
    logic       nxt_own;
    logic [2:0] nxt_idx;
    logic [7:0] nxt_sel;
    // Rotate so the pointer sits at bit 0, find the lowest set bit, then rotate back.
    assign rot = 8'({bus.req, bus.req} >> ptr);
    always_comb begin
        first = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) first = 3'(i);
    end
    assign win         = ptr + first;
    assign ena_on      = bus.ena == ENA_ON;
    assign rel_early   = !ena_on || bus.done || !bus.req[bus.gnt_idx];
    assign rel_hold    = cnt == HOLD_LAST;
    assign release_own = rel_early || rel_hold;
    assign grant       = state == ST_IDLE && ena_on && |bus.req;
    assign nxt_own     = grant || (state == ST_OWN && !release_own);
    assign nxt_idx     = grant ? win : bus.gnt_idx;
    sel_dec3to8 u_dec (
        .idx  (nxt_idx),
        .en   (nxt_own),
        .sel_n(nxt_sel)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= 3'd0;
            cnt         <= 8'd0;
            bus.sel_n   <= SEL_NONE;
            bus.gnt_idx <= 3'd0;
            bus.valid   <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.sel_n   <= nxt_sel;
            bus.gnt_idx <= nxt_idx;
            bus.valid   <= nxt_own;
            // A timeout is reported only when the hold limit is the sole reason for release.
            bus.timeout <= state == ST_OWN && rel_hold && !rel_early;
            case (state)
                ST_IDLE: if (grant) begin
                    state <= ST_OWN;
                    cnt   <= 8'd0;
                end
                ST_OWN: if (release_own) begin
                    state <= ST_GAP;
                    ptr   <= bus.gnt_idx + 3'd1;
                end else begin
                    cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed checks of grant order, gap spacing, timeout, disable and reset
module tb_rr_sel_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    rr_sel_arbiter_if a_if ();
    rr_sel_arbiter_if b_if ();
    rr_sel_arbiter #(.MAX_HOLD(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    rr_sel_arbiter #(.MAX_HOLD(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_a(input string tag, input logic [7:0] sel, input logic [2:0] idx,
                            input logic v, input logic to);
        check({tag, ".sel_n"}, 32'(a_if.sel_n), 32'(sel));
        check({tag, ".gnt_idx"}, 32'(a_if.gnt_idx), 32'(idx));
        check({tag, ".valid"}, 32'(a_if.valid), 32'(v));
        check({tag, ".timeout"}, 32'(a_if.timeout), 32'(to));
    endtask
    task automatic expect_b(input string tag, input logic [7:0] sel, input logic [2:0] idx,
                            input logic v, input logic to);
        check({tag, ".sel_n"}, 32'(b_if.sel_n), 32'(sel));
        check({tag, ".gnt_idx"}, 32'(b_if.gnt_idx), 32'(idx));
        check({tag, ".valid"}, 32'(b_if.valid), 32'(v));
        check({tag, ".timeout"}, 32'(b_if.timeout), 32'(to));
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask
    initial begin
        a_if.ena = 2'b00; a_if.req = 8'h00; a_if.done = 1'b0;
        b_if.ena = 2'b00; b_if.req = 8'h00; b_if.done = 1'b0;
        do_reset();
        expect_a("rst", 8'hFF, 3'd0, 1'b0, 1'b0);
        expect_b("rst_b", 8'hFF, 3'd0, 1'b0, 1'b0);
        // single request from 2
        a_if.ena = 2'b01; a_if.req = 8'h04;
        tick();
        expect_a("t1.grant", 8'hFB, 3'd2, 1'b1, 1'b0);
        a_if.req = 8'h00;
        tick();
        expect_a("t1.rel", 8'hFF, 3'd2, 1'b0, 1'b0);
        tick();
        // full round-robin with done pulsed in each owner cycle
        do_reset();
        a_if.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            expect_a($sformatf("t2.g%0d", i), ~(8'b1 << (i % 8)), 3'(i % 8), 1'b1, 1'b0);
            a_if.done = 1'b1;
            tick();
            check($sformatf("t2.gap1_%0d", i), 32'(a_if.sel_n), 32'hFF);
            a_if.done = 1'b0;
            tick();
            check($sformatf("t2.gap2_%0d", i), 32'(a_if.sel_n), 32'hFF);
        end
        a_if.req = 8'h00;
        // hold limit of 4 with a lone requester 5
        do_reset();
        a_if.req = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_a($sformatf("t3.own%0d", i), 8'hDF, 3'd5, 1'b1, 1'b0);
        end
        tick();
        expect_a("t3.tmo", 8'hFF, 3'd5, 1'b0, 1'b1);
        tick();
        expect_a("t3.gap", 8'hFF, 3'd5, 1'b0, 1'b0);
        tick();
        expect_a("t3.regrant", 8'hDF, 3'd5, 1'b1, 1'b0);
        a_if.req = 8'h00;
        tick();
        tick();
        // disable mid-grant: pointer is 6, only requester 3 asks
        a_if.req = 8'h08;
        tick();
        expect_a("t4.grant", 8'hF7, 3'd3, 1'b1, 1'b0);
        a_if.ena = 2'b10; a_if.req = 8'hFF;
        tick();
        expect_a("t4.rel", 8'hFF, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_a($sformatf("t4.off%0d", i), 8'hFF, 3'd3, 1'b0, 1'b0);
        end
        // reset mid-grant clears the pointer
        a_if.ena = 2'b01; a_if.req = 8'h40;
        tick();
        expect_a("t5.grant", 8'hBF, 3'd6, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_a("t5.rst", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1; a_if.req = 8'hC1;
        tick();
        expect_a("t5.ptr0", 8'hFE, 3'd0, 1'b1, 1'b0);
        a_if.req = 8'h00;
        // MAX_HOLD=1: done coinciding with the limit suppresses timeout
        b_if.ena = 2'b01; b_if.req = 8'h02;
        tick();
        expect_b("t6.grant", 8'hFD, 3'd1, 1'b1, 1'b0);
        b_if.done = 1'b1;
        tick();
        expect_b("t6.done", 8'hFF, 3'd1, 1'b0, 1'b0);
        b_if.done = 1'b0;
        tick();
        expect_b("t6.gap", 8'hFF, 3'd1, 1'b0, 1'b0);
        tick();
        expect_b("t6.regrant", 8'hFD, 3'd1, 1'b1, 1'b0);
        tick();
        expect_b("t6.tmo", 8'hFF, 3'd1, 1'b0, 1'b1);
        tick();
        expect_b("t6.after", 8'hFF, 3'd1, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
8-way round-robin arbiter that shares one resource among requesters 0..7.
- Drives an active-low one-hot select bus of the same form as the team's 3-to-8 decoder: one line low = selected, 8'hFF = none.
- Sequences grant, hold, forced timeout and release, with a guaranteed one-cycle dead gap between owners.
- Sits between requesting units and the shared resource's chip-select lines.

Parameters:
MAX_HOLD, 16, maximum cycles one owner may hold the grant before forced release; legal range 1..255.

Ports:
iClk  input  1  clock; all logic on rising edge.
iRst_n  input  1  reset, synchronous, active-low.
iEna  input  2  arbitration enable; only 2'b01 enables, any other value disables.
iReq  input  8  request per requester, active-high, level-held while wanted.
iDone  input  1  current owner releases the resource (sampled only in OWN).
oSel_n  output  8  active-low one-hot select; 8'hFF when no owner.
oGntIdx  output  3  index of current or last owner.
oValid  output  1  high while a grant is active (equals ~&oSel_n).
oTimeout  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Behaviour:
- All outputs registered.
- Reset (iRst_n=0 at an edge):
  - state=IDLE, oSel_n=8'hFF, oGntIdx=0, oValid=0, oTimeout=0.
  - Priority pointer=0, hold counter=0.
  - Reset overrides everything, including mid-grant; the select drops to 8'hFF at that edge.
- States: IDLE, OWN, GAP.
- IDLE:
  - If iEna==2'b01 and |iReq, the winner is the first set iReq bit searching from the pointer upward with wrap 7->0.
  - At that edge: oGntIdx=winner, oSel_n=~(8'b1<<winner), counter=0, go to OWN.
  - Latency: request sampled at edge k -> select low after edge k.
  - Otherwise stay in IDLE with oSel_n=8'hFF.
- OWN: counter increments each cycle, 8-bit, saturating. Release conditions at an edge, in priority order:
  - (a) iEna!=2'b01;
  - (b) iDone=1;
  - (c) iReq[oGntIdx]=0;
  - (d) counter==MAX_HOLD-1, which also sets oTimeout=1 for exactly that following cycle.
  - On any release: oSel_n=8'hFF, oValid=0, pointer=(oGntIdx+1) mod 8, go to GAP.
  - If (d) coincides with (a), (b) or (c), release still occurs and oTimeout is not asserted.
  - MAX_HOLD=1 gives exactly one OWN cycle.
- GAP:
  - Exactly one cycle, all deselected; then unconditionally return to IDLE.
  - Requests sampled in GAP are ignored.
  - Minimum spacing between two grants is 2 cycles of 8'hFF: GAP plus the IDLE arbitration edge.
- Round-robin rules:
  - A continuously requesting set is served in index order starting after the last owner.
  - Starvation bound: 7 other grants.
- Invariants:
  - oSel_n has at most one zero bit at all times.
  - oGntIdx holds its value after release.

Decomposition:
- Package rr_sel_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_OWN=2'd1, ST_GAP=2'd2;
  - SEL_NONE=8'hFF;
  - ENA_ON=2'b01.
- One sub-module, sel_dec3to8: combinational 3-to-8 active-low decoder with enable. It converts the registered winner index plus the owned flag into the next oSel_n value before the output register.
- Priority search (rotate, find-first, un-rotate) stays in the top module.

Test Plan:
1. Reset, then iEna=01, iReq=8'b0000_0100 -> 1 cycle later oSel_n=8'b1111_1011, oGntIdx=2, oValid=1.
2. iReq=8'hFF held, iDone pulsed each OWN cycle -> grant order 0,1,2,…,7,0. Every pair of grants is separated by exactly 2 cycles of oSel_n=8'hFF.
3. MAX_HOLD=4, single requester 5 never asserts iDone -> oSel_n=8'b1101_1111 for 4 cycles, then 8'hFF with oTimeout=1 for one cycle. After GAP+IDLE it is re-granted to 5.
4. Owner 3 active, iEna driven to 2'b10 -> next edge oSel_n=8'hFF, oTimeout=0. No new grant while iEna!=01 even with iReq=8'hFF.
5. Owner 6 active, iRst_n=0 for one edge -> oSel_n=8'hFF, oGntIdx=0. Next grant with iReq=8'hC1 goes to 0, because the pointer was reset.
6. MAX_HOLD=1, iDone=1 in the single OWN cycle -> release with oTimeout=0 (simultaneous-event priority).
